// File: rtl/tb_ctrl_periph.sv
// Testbench control peripheral: stdout FIFO, 64-bit cycle counter and an
// exit FSM that drains stdout, waits a settle delay, then raises pass/fail.
module tb_ctrl_periph #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          DRAIN_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        char_valid_o,
    output logic [7:0]  char_o,
    input  logic        char_ready_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic [31:0] exit_code_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, HOLD, DONE} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [63:0]    cycle_q, cycle_d;
    logic [31:0]    shadow_q, shadow_d;
    logic [31:0]    exit_q, exit_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           rvalid_q, rvalid_d;
    logic           passed_q, passed_d;
    logic           failed_q, failed_d;
    logic [AW:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0]     fifo_mem_q [FIFO_DEPTH];

    logic        sel, stall, gnt, wr, rd, push, pop, full, empty, exit_acc;
    logic [2:0]  off;
    logic [AW:0] level;

    assign off   = data_addr_i[4:2];
    assign sel   = data_req_i && (data_addr_i[31:5] == BASE_ADDR[31:5]);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign level = wptr_q - rptr_q;
    // Stall only on the registered full flag, so a same-cycle pop never
    // lets a push through.
    assign stall = data_we_i && (off == 3'd0) && full;
    assign gnt   = sel && !stall;
    assign wr    = gnt && data_we_i;
    assign rd    = gnt && !data_we_i;
    assign push  = wr && (off == 3'd0) && data_be_i[0];
    assign pop   = !empty && char_ready_i;
    assign exit_acc = wr && (off == 3'd1) && (data_be_i == 4'hF) && (state_q == RUN);

    always_comb begin
        cycle_d  = cycle_q + 64'd1;
        shadow_d = shadow_q;
        exit_d   = exit_q;
        rvalid_d = gnt;
        rdata_d  = 32'd0;
        wptr_d   = wptr_q + {{AW{1'b0}}, push};
        rptr_d   = rptr_q + {{AW{1'b0}}, pop};
        state_d  = state_q;
        cnt_d    = cnt_q;
        passed_d = passed_q;
        failed_d = failed_q;

        if (rd) begin
            case (off)
                3'd0: rdata_d = {24'd0, 8'(level)};
                3'd1: rdata_d = exit_q;
                3'd2: begin
                    rdata_d  = cycle_q[31:0];
                    shadow_d = cycle_q[63:32];
                end
                3'd3: rdata_d = shadow_q;
                3'd4: rdata_d = {29'd0, state_q != RUN, empty, full};
                default: rdata_d = 32'd0;
            endcase
        end

        case (state_q)
            RUN: if (exit_acc) begin
                exit_d  = data_wdata_i;
                state_d = DRAIN;
            end
            DRAIN: if (empty) begin
                state_d = HOLD;
                cnt_d   = CW'(DRAIN_CYCLES - 1);
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    passed_d = (exit_q == 32'd0);
                    failed_d = (exit_q != 32'd0);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            cycle_q  <= '0;
            shadow_q <= '0;
            exit_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            passed_q <= 1'b0;
            failed_q <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cycle_q  <= cycle_d;
            shadow_q <= shadow_d;
            exit_q   <= exit_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            passed_q <= passed_d;
            failed_q <= failed_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
        end
    end

    // Storage needs no reset; pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wptr_q[AW-1:0]] <= data_wdata_i[7:0];
    end

    assign data_gnt_o     = gnt;
    assign data_rvalid_o  = rvalid_q;
    assign data_rdata_o   = rdata_q;
    assign char_valid_o   = !empty;
    assign char_o         = fifo_mem_q[rptr_q[AW-1:0]];
    assign tests_passed_o = passed_q;
    assign tests_failed_o = failed_q;
    assign exit_code_o    = exit_q;
endmodule

// File: tb/tb_tb_ctrl_periph.sv
// Directed bench for tb_ctrl_periph: bus accesses, stdout FIFO flow control,
// cycle counter snapshot and the exit drain/hold sequence.
module tb_tb_ctrl_periph;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] A_STDOUT = BASE + 32'h00;
    localparam logic [31:0] A_EXIT   = BASE + 32'h04;
    localparam logic [31:0] A_LO     = BASE + 32'h08;
    localparam logic [31:0] A_HI     = BASE + 32'h0C;
    localparam logic [31:0] A_STAT   = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_req = 1'b0;
    logic [31:0] data_addr = '0;
    logic        data_we = 1'b0;
    logic [3:0]  data_be = '0;
    logic [31:0] data_wdata = '0;
    logic        data_gnt, data_rvalid, char_valid, tests_passed, tests_failed;
    logic [31:0] data_rdata, exit_code;
    logic [7:0]  char_o;
    logic        char_ready = 1'b0;

    int          n_vec = 0;
    int          n_err = 0;
    longint      tb_cyc;
    logic [7:0]  cap[$];

    tb_ctrl_periph #(.BASE_ADDR(BASE), .FIFO_DEPTH(16), .DRAIN_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
        .data_be_i(data_be), .data_wdata_i(data_wdata),
        .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
        .char_valid_o(char_valid), .char_o(char_o), .char_ready_i(char_ready),
        .tests_passed_o(tests_passed), .tests_failed_o(tests_failed),
        .exit_code_o(exit_code)
    );

    always #5 clk = ~clk;

    // Reference cycle count, independent of the DUT counter.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    always @(posedge clk) begin
        if (rst_n && char_valid && char_ready) cap.push_back(char_o);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        data_req = 1'b0;
        char_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after the grant edge.
    task automatic bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rd, output longint cyc);
        int w = 0;
        data_req = 1'b1; data_we = we; data_addr = addr; data_be = be; data_wdata = wd;
        #1;
        while (!data_gnt && w < 100) begin
            @(negedge clk); #1; w++;
        end
        rd = '0; cyc = 0;
        if (!data_gnt) begin
            chk("gnt_timeout", {63'd0, data_gnt}, 64'd1);
            data_req = 1'b0;
            @(negedge clk);
            return;
        end
        cyc = tb_cyc;
        @(posedge clk);
        @(negedge clk);
        data_req = 1'b0;
        chk("rvalid", {63'd0, data_rvalid}, 64'd1);
        rd = data_rdata;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] r; longint c;
        bus(1'b1, addr, be, wd, r, c);
    endtask

    task automatic rdreg(input logic [31:0] addr, output logic [31:0] r);
        longint c;
        bus(1'b0, addr, 4'hF, 32'd0, r, c);
    endtask

    task automatic wait_flag(input bit want_fail, output int n);
        n = 0;
        while (!(want_fail ? tests_failed : tests_passed) && n < 60) begin
            @(negedge clk); n++;
        end
    endtask

    initial begin
        logic [31:0] r;
        longint      c;
        int          base, n;

        // Reset state and cycle counter snapshot
        do_reset();
        chk("rst_rvalid", {63'd0, data_rvalid}, 64'd0);
        chk("rst_cvalid", {63'd0, char_valid}, 64'd0);
        chk("rst_pass", {62'd0, tests_passed, tests_failed}, 64'd0);
        chk("rst_exit", {32'd0, exit_code}, 64'd0);
        while (tb_cyc != 10) @(negedge clk);
        bus(1'b0, A_LO, 4'hF, 32'd0, r, c);
        chk("cyc_lo", {32'd0, r}, 64'd10);
        chk("cyc_ref", c, 64'd10);
        @(negedge clk);
        chk("rvalid_one", {63'd0, data_rvalid}, 64'd0);
        rdreg(A_HI, r);
        chk("cyc_hi", {32'd0, r}, 64'd0);

        // "Hi\n" through the FIFO with ready held high
        char_ready = 1'b1;
        base = cap.size();
        wr(A_STDOUT, 4'h1, 32'h48);
        wr(A_STDOUT, 4'h1, 32'h69);
        wr(A_STDOUT, 4'h1, 32'h0A);
        repeat (3) @(negedge clk);
        chk("hi_cnt", 64'(cap.size() - base), 64'd3);
        if (cap.size() - base == 3) begin
            chk("hi_c0", {56'd0, cap[base]}, 64'h48);
            chk("hi_c1", {56'd0, cap[base+1]}, 64'h69);
            chk("hi_c2", {56'd0, cap[base+2]}, 64'h0A);
        end
        rdreg(A_STAT, r);
        chk("stat_empty", {32'd0, r}, 64'h2);

        // Fill FIFO, 17th write stalls until one pop frees a slot
        char_ready = 1'b0;
        base = cap.size();
        for (int i = 0; i < 16; i++) wr(A_STDOUT, 4'h1, 32'h41 + 32'(i));
        rdreg(A_STAT, r);
        chk("stat_full", {32'd0, r}, 64'h1);
        rdreg(A_STDOUT, r);
        chk("level_full", {32'd0, r}, 64'd16);
        data_req = 1'b1; data_we = 1'b1; data_addr = A_STDOUT; data_be = 4'h1; data_wdata = 32'h51;
        #1 chk("stall0", {63'd0, data_gnt}, 64'd0);
        @(negedge clk);
        #1 chk("stall1", {63'd0, data_gnt}, 64'd0);
        char_ready = 1'b1;
        #1 chk("stall_pop", {63'd0, data_gnt}, 64'd0);
        @(negedge clk);
        char_ready = 1'b0;
        #1 chk("unstall", {63'd0, data_gnt}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        data_req = 1'b0;
        chk("unstall_rv", {63'd0, data_rvalid}, 64'd1);
        char_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("full_cnt", 64'(cap.size() - base), 64'd17);
        if (cap.size() - base == 17)
            for (int i = 0; i < 17; i++) chk("full_seq", {56'd0, cap[base+i]}, 64'h41 + 64'(i));

        // EXIT=0 with 3 chars queued: 3 pops + 1 empty detect + 8 hold = 12
        char_ready = 1'b0;
        base = cap.size();
        wr(A_STDOUT, 4'h1, 32'h61);
        wr(A_STDOUT, 4'h1, 32'h62);
        wr(A_STDOUT, 4'h1, 32'h63);
        wr(A_EXIT, 4'hF, 32'd0);
        rdreg(A_STAT, r);
        chk("stat_drain", {32'd0, r}, 64'h4);
        char_ready = 1'b1;
        wait_flag(1'b0, n);
        chk("drain_cycles", 64'(n), 64'd12);
        chk("pass_flags", {62'd0, tests_passed, tests_failed}, 64'h2);
        chk("pass_code", {32'd0, exit_code}, 64'd0);
        chk("drain_chars", 64'(cap.size() - base), 64'd3);

        // Nonzero exit; later EXIT writes and partial-byte writes ignored
        do_reset();
        wr(A_EXIT, 4'h3, 32'd7);
        rdreg(A_EXIT, r);
        chk("exit_be", {32'd0, r}, 64'd0);
        wr(A_EXIT, 4'hF, 32'd5);
        wr(A_EXIT, 4'hF, 32'd0);
        wait_flag(1'b1, n);
        chk("fail_flags", {62'd0, tests_passed, tests_failed}, 64'h1);
        chk("fail_code", {32'd0, exit_code}, 64'd5);
        rdreg(A_EXIT, r);
        chk("fail_rd", {32'd0, r}, 64'd5);

        // Reset during HOLD, then a clean run
        do_reset();
        wr(A_EXIT, 4'hF, 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("hrst_flags", {62'd0, tests_passed, tests_failed}, 64'd0);
        chk("hrst_rvalid", {63'd0, data_rvalid}, 64'd0);
        do_reset();
        rdreg(A_STAT, r);
        chk("hrst_stat", {32'd0, r}, 64'h2);
        wr(A_EXIT, 4'hF, 32'd0);
        wait_flag(1'b0, n);
        chk("rerun_flags", {62'd0, tests_passed, tests_failed}, 64'h2);
        rdreg(BASE + 32'h18, r);
        chk("unmapped", {32'd0, r}, 64'd0);
        data_req = 1'b1; data_we = 1'b0; data_addr = BASE + 32'h20;
        #1 chk("out_of_win", {63'd0, data_gnt}, 64'd0);
        data_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
